// File: rtl/wr_sched_pkg.sv
// Shared types for the capture-ring write scheduler: FSM states, queued descriptor
// payload and the word-rounding helper.
package wr_sched_pkg;

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned RLEN_W = 17;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALLOC = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [LEN_W-1:0] len;
  } desc_t;

  // Round a byte length up to a whole 32-bit word; one extra bit holds 65535 -> 65536.
  function automatic logic [RLEN_W-1:0] round_to_word(input logic [LEN_W-1:0] len);
    logic [RLEN_W-1:0] sum;
    sum = RLEN_W'(len) + RLEN_W'(3);
    return sum & ~RLEN_W'(3);
  endfunction

endpackage

// File: rtl/wr_sched_fifo.sv
// Synchronous descriptor FIFO with registered full/empty flags and occupancy count.
// DEPTH must be a power of two, at least 2.
module wr_sched_fifo
  import wr_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  desc_t            din_i,
  input  logic             pop_i,
  output desc_t            dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  desc_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_idx_q;
  logic [PTR_W-1:0] rd_idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             full_q;
  logic             empty_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;
  assign cnt_d   = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_idx_q] <= din_i;
    end
  end

  // Indices wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_idx_q <= wr_idx_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_idx_q <= rd_idx_q + PTR_W'(1);
      end
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNT_W'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  assign dout_o  = mem_q[rd_idx_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/wr_sched.sv
// Capture-ring write scheduler: queues packet descriptors, allocates ring space
// without straddling the ring end, and hands one packet at a time to the write
// controller. Optional statistics ports are enabled by defining WR_SCHED_STATS_EN.
module wr_sched
  import wr_sched_pkg::*;
#(
  parameter int unsigned RING_BYTES = 4096,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned QDEPTH     = 4,
  localparam int unsigned PTR_W     = $clog2(RING_BYTES) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             desc_valid,
  input  logic [15:0]      desc_len,
  output logic             desc_ready,
  output logic             wr_ctrl,
  output logic [31:0]      pkt_begin,
  output logic [31:0]      pkt_end,
  output logic [31:0]      control,
  input  logic             wr_ctrl_rdy,
  input  logic [PTR_W-1:0] host_rd_ptr,
  output logic [PTR_W-1:0] wr_ptr,
`ifdef WR_SCHED_STATS_EN
  output logic [31:0]      pkt_cnt,
  output logic [15:0]      drop_cnt,
  output logic [31:0]      stall_cycles,
`endif
  output logic             busy
);

  localparam int unsigned OFF_W  = PTR_W - 1;
  localparam int unsigned CALC_W = 32;
  localparam int unsigned QCNT_W = $clog2(QDEPTH) + 1;
  localparam logic [CALC_W-1:0] RING_C = CALC_W'(RING_BYTES);

  state_e state_q;
  state_e state_d;

  desc_t             head;
  desc_t             din;
  logic              fifo_full;
  logic              fifo_empty;
  logic [QCNT_W-1:0] fifo_cnt;
  logic [QCNT_W-1:0] cnt_next;
  logic              push;
  logic              pop;
  logic              load;
  logic              commit;

  logic [RLEN_W-1:0] rlen;
  logic [CALC_W-1:0] rlen_w;
  logic [CALC_W-1:0] off;
  logic [CALC_W-1:0] skip;
  logic [PTR_W-1:0]  used;
  logic [PTR_W-1:0]  free_p;
  logic [CALC_W-1:0] free_w;
  logic [OFF_W-1:0]  begin_off;
  logic [31:0]       begin_addr;
  logic              too_big;
  logic              stall;
  logic              busy_d;

  logic              wr_ctrl_q;
  logic [31:0]       pkt_begin_q;
  logic [31:0]       pkt_end_q;
  logic [31:0]       control_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  adv_q;
  logic [15:0]       seq_q;
  logic              busy_q;

  // Zero-length descriptors are handshaken but never enter the queue.
  assign push    = desc_valid && !fifo_full && (desc_len != '0);
  assign din.len = desc_len;

  wr_sched_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Allocation datapath for the queue head against the committed producer pointer.
  always_comb begin
    rlen       = round_to_word(head.len);
    rlen_w     = CALC_W'(rlen);
    off        = CALC_W'(wr_ptr_q[OFF_W-1:0]);
    skip       = ((off + rlen_w) > RING_C) ? (RING_C - off) : '0;
    used       = wr_ptr_q - host_rd_ptr;
    free_p     = PTR_W'(RING_BYTES) - used;
    free_w     = CALC_W'(free_p);
    too_big    = rlen_w > RING_C;
    stall      = (skip + rlen_w) > free_w;
    begin_off  = OFF_W'(off + skip);
    begin_addr = BASE_ADDR + 32'(begin_off);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_ALLOC;
        end
      end
      S_ALLOC: begin
        if (too_big) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end else if (!stall) begin
          load    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (wr_ctrl_rdy) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        pop     = 1'b1;
        commit  = 1'b1;
        state_d = ((fifo_cnt > QCNT_W'(1)) || push) ? S_ALLOC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cnt_next = fifo_cnt + QCNT_W'(push) - QCNT_W'(pop);
  assign busy_d   = (state_d != S_IDLE) || (cnt_next != '0);

  // Packet window is captured once on leaving ALLOC and held through ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ctrl_q   <= 1'b0;
      pkt_begin_q <= BASE_ADDR;
      pkt_end_q   <= BASE_ADDR;
      control_q   <= '0;
      wr_ptr_q    <= '0;
      adv_q       <= '0;
      seq_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      wr_ctrl_q <= (state_d == S_ISSUE);
      busy_q    <= busy_d;
      if (load) begin
        pkt_begin_q <= begin_addr;
        pkt_end_q   <= begin_addr + 32'(rlen);
        control_q   <= {seq_q, rlen[15:0]};
        adv_q       <= PTR_W'(skip + rlen_w);
      end
      if (commit) begin
        wr_ptr_q <= wr_ptr_q + adv_q;
        seq_q    <= seq_q + 16'd1;
      end
    end
  end

`ifdef WR_SCHED_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [15:0] drop_cnt_q;
  logic [31:0] stall_q;
  logic        drop_hit;
  logic        stall_hit;

  assign drop_hit  = (state_q == S_ALLOC) && too_big;
  assign stall_hit = (state_q == S_ALLOC) && !too_big && stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      stall_q    <= '0;
    end else begin
      if (commit) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
      if (drop_hit && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
      if (stall_hit && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign pkt_cnt      = pkt_cnt_q;
  assign drop_cnt     = drop_cnt_q;
  assign stall_cycles = stall_q;
`endif

  assign desc_ready = !fifo_full;
  assign wr_ctrl    = wr_ctrl_q;
  assign pkt_begin  = pkt_begin_q;
  assign pkt_end    = pkt_end_q;
  assign control    = control_q;
  assign wr_ptr     = wr_ptr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_wr_sched.sv
// Bench for wr_sched: descriptor table with a dispatch scoreboard, plus directed
// sequences for queue-full, reset during ISSUE, ring-end skip and space stall.
module tb_wr_sched;

  localparam int unsigned RING = 4096;
  localparam int unsigned PW   = 13;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          desc_valid;
  logic [15:0]   desc_len;
  logic          desc_ready;
  logic          wr_ctrl;
  logic [31:0]   pkt_begin;
  logic [31:0]   pkt_end;
  logic [31:0]   control;
  logic          wr_ctrl_rdy;
  logic [PW-1:0] host_rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          busy;
`ifdef WR_SCHED_STATS_EN
  logic [31:0]   pkt_cnt;
  logic [15:0]   drop_cnt;
  logic [31:0]   stall_cycles;
`endif

  wr_sched #(
    .RING_BYTES (RING),
    .BASE_ADDR  (BASE),
    .QDEPTH     (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .desc_valid   (desc_valid),
    .desc_len     (desc_len),
    .desc_ready   (desc_ready),
    .wr_ctrl      (wr_ctrl),
    .pkt_begin    (pkt_begin),
    .pkt_end      (pkt_end),
    .control      (control),
    .wr_ctrl_rdy  (wr_ctrl_rdy),
    .host_rd_ptr  (host_rd_ptr),
    .wr_ptr       (wr_ptr),
`ifdef WR_SCHED_STATS_EN
    .pkt_cnt      (pkt_cnt),
    .drop_cnt     (drop_cnt),
    .stall_cycles (stall_cycles),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] b;
    logic [31:0] e;
    logic [31:0] c;
    int          gap;
  } exp_t;

  typedef struct {
    bit          rst;
    logic [15:0] len;
    bit          disp;
    logic [31:0] b_off;
    logic [31:0] e_off;
    logic [31:0] ctl;
    int          gap;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   checks = 0;
  int   passed = 0;
  bit   auto_rdy = 1'b1;
  int   rdy_delay = 1;
  int   hold_cnt = 0;
  bit   prev_wc = 1'b0;
  int   low_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Write-controller model: acknowledges after rdy_delay cycles of wr_ctrl.
  initial begin
    wr_ctrl_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_ctrl && auto_rdy && !reset) begin
        hold_cnt++;
        wr_ctrl_rdy = (hold_cnt >= rdy_delay);
      end else begin
        hold_cnt    = 0;
        wr_ctrl_rdy = 1'b0;
      end
    end
  end

  // Dispatch monitor: each rising wr_ctrl must match the oldest expected packet.
  always @(negedge clk) begin
    if (reset) begin
      prev_wc = 1'b0;
      low_run = 0;
    end else begin
      if (wr_ctrl && !prev_wc) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_dispatch: got begin 0x%0h expected no packet", pkt_begin);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pkt_begin", pkt_begin, e.b);
          chk("pkt_end", pkt_end, e.e);
          chk("control", control, e.c);
          if (e.gap != 0) chk("low_gap", 32'(low_run), 32'(e.gap));
        end
      end
      if (wr_ctrl) low_run = 0;
      else low_run++;
      prev_wc = wr_ctrl;
    end
  end

  task automatic do_reset();
    reset      = 1'b1;
    desc_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns on the negedge after the accepting clock edge.
  task automatic send(input logic [15:0] len);
    bit ok;
    ok         = 1'b0;
    desc_len   = len;
    desc_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (desc_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      $display("FAIL send_timeout: got desc_ready low expected accept of len %0d", len);
    end
    @(negedge clk);
    desc_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy && !wr_ctrl) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      $display("FAIL idle_timeout: got busy=%0b expected 0", busy);
    end
  endtask

  initial begin
    int highs;
    reset       = 1'b1;
    desc_valid  = 1'b0;
    desc_len    = '0;
    host_rd_ptr = '0;

    //            rst  len     disp b_off e_off ctl             gap
    vecs[0] = '{1'b1, 16'd32,    1'b1, 0,  32, {16'd0, 16'd32}, 0};
    vecs[1] = '{1'b0, 16'd4,     1'b1, 32, 36, {16'd1, 16'd4},  2};
    vecs[2] = '{1'b1, 16'd5,     1'b1, 0,  8,  {16'd0, 16'd8},  0};
    vecs[3] = '{1'b0, 16'd8,     1'b1, 8,  16, {16'd1, 16'd8},  2};
    vecs[4] = '{1'b0, 16'd60,    1'b1, 16, 76, {16'd2, 16'd60}, 2};
    vecs[5] = '{1'b0, 16'd0,     1'b0, 0,  0,  32'd0,           0};
    vecs[6] = '{1'b0, 16'd1,     1'b1, 76, 80, {16'd3, 16'd4},  2};
    vecs[7] = '{1'b0, 16'd65535, 1'b0, 0,  0,  32'd0,           0};
    vecs[8] = '{1'b0, 16'd2,     1'b1, 80, 84, {16'd4, 16'd4},  4};

    do_reset();
    chk("rst_desc_ready", 32'(desc_ready), 32'd1);
    chk("rst_wr_ctrl", 32'(wr_ctrl), 32'd0);
    chk("rst_pkt_begin", pkt_begin, BASE);
    chk("rst_pkt_end", pkt_end, BASE);
    chk("rst_control", control, 32'd0);
    chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef WR_SCHED_STATS_EN
    chk("rst_pkt_cnt", pkt_cnt, 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_stall", stall_cycles, 32'd0);
`endif

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].rst) begin
        wait_idle();
        do_reset();
      end
      if (vecs[i].disp)
        sb.push_back('{BASE + vecs[i].b_off, BASE + vecs[i].e_off, vecs[i].ctl, vecs[i].gap});
      send(vecs[i].len);
      if (i == 0) begin
        // Accept at cycle N: IDLE in N+1, ALLOC in N+2, wr_ctrl high in N+3.
        chk("lat_n1", 32'(wr_ctrl), 32'd0);
        @(negedge clk);
        chk("lat_n2", 32'(wr_ctrl), 32'd0);
        @(negedge clk);
        chk("lat_n3", 32'(wr_ctrl), 32'd1);
      end
    end
    wait_idle();
    chk("table_wr_ptr", 32'(wr_ptr), 32'd84);
`ifdef WR_SCHED_STATS_EN
    chk("table_pkt_cnt", pkt_cnt, 32'd5);
    chk("table_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

    // Queue fills while the head is held in ISSUE, then reset mid-ISSUE.
    auto_rdy = 1'b0;
    do_reset();
    sb.push_back('{BASE, BASE + 32'd4, {16'd0, 16'd4}, 0});
    repeat (4) send(16'd4);
    chk("full_desc_ready", 32'(desc_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    chk("full_wr_ctrl", 32'(wr_ctrl), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_issue_wr_ctrl", 32'(wr_ctrl), 32'd0);
    chk("rst_issue_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_issue_ready", 32'(desc_ready), 32'd1);
    chk("rst_issue_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    auto_rdy = 1'b1;
    highs = 0;
    repeat (6) begin
      @(negedge clk);
      highs += int'(wr_ctrl);
    end
    chk("rst_issue_no_replay", 32'(highs), 32'd0);

    // Ring-end skip: 64 bytes at offset 4064 restart at ring offset 0.
    do_reset();
    host_rd_ptr = '0;
    sb.push_back('{BASE, BASE + 32'd4064, {16'd0, 16'd4064}, 0});
    send(16'd4064);
    wait_idle();
    chk("wrap_pre_wr_ptr", 32'(wr_ptr), 32'd4064);
    host_rd_ptr = 13'd4064;
    sb.push_back('{BASE, BASE + 32'd64, {16'd1, 16'd64}, 0});
    send(16'd64);
    wait_idle();
    chk("wrap_wr_ptr", 32'(wr_ptr), 32'd4160);

    // Space stall until the host consumer advances.
    do_reset();
    host_rd_ptr = '0;
    sb.push_back('{BASE, BASE + 32'd4000, {16'd0, 16'd4000}, 0});
    send(16'd4000);
    wait_idle();
    chk("stall_pre_wr_ptr", 32'(wr_ptr), 32'd4000);
    sb.push_back('{BASE, BASE + 32'd200, {16'd1, 16'd200}, 0});
    send(16'd200);
    highs = 0;
    repeat (20) begin
      @(negedge clk);
      highs += int'(wr_ctrl);
    end
    chk("stall_no_dispatch", 32'(highs), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
    host_rd_ptr = 13'd300;
    wait_idle();
    chk("stall_wr_ptr", 32'(wr_ptr), 32'd4296);
`ifdef WR_SCHED_STATS_EN
    chk("stall_cycles", stall_cycles, 32'd19);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
